// File: rtl/video_wr_buffer_if.sv
// Pixel-in / word-out bundle between a video source, video_wr_buffer and one
// DDR write arbiter channel.
interface video_wr_buffer_if #(
  parameter int DEPTH = 64
);
  logic                     pix_vsync;
  logic                     pix_de;
  logic [15:0]              pix_data;
  logic                     channel_rready;
  logic                     rd_en;
  logic [255:0]             rd_data;
  logic                     frame_end_flag;
  logic                     wr_overflow;
  logic                     rd_underflow;
  logic [$clog2(DEPTH):0]   fill_count;

  modport master (
    output pix_vsync, pix_de, pix_data, rd_en,
    input  channel_rready, rd_data, frame_end_flag, wr_overflow, rd_underflow, fill_count
  );

  modport slave (
    input  pix_vsync, pix_de, pix_data, rd_en,
    output channel_rready, rd_data, frame_end_flag, wr_overflow, rd_underflow, fill_count
  );
endinterface

// File: rtl/video_wr_buffer.sv
// Packs 16-bit pixels into 256-bit words, buffers them and pads each frame to a
// burst boundary. Define TEST_PATTERN_EN to replace pixels with a per-frame counter.

module vwb_lane #(
  parameter int VEC_W = 16
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             sel_new,
  input  logic             keep,
  input  logic [VEC_W-1:0] din,
  output logic [VEC_W-1:0] q
);
  logic [VEC_W-1:0] r;

  always_ff @(posedge clk) begin
    if (rst)     r <= '0;
    else if (ld) r <= din;
  end

  // sel_new forwards the incoming pixel so a full word can be pushed on the 16th beat
  assign q = sel_new ? din : (keep ? r : '0);
endmodule

module video_wr_buffer #(
  parameter int DEPTH     = 64,
  parameter int BURST_LEN = 16
)(
  input logic           clk,
  input logic           rst,
  video_wr_buffer_if.slave bus
);
  localparam int NUM_LANES = 16;
  localparam int VEC_W     = 16;
  localparam int AW        = $clog2(DEPTH);
  localparam int BW        = $clog2(BURST_LEN);
  localparam int KW        = $clog2(NUM_LANES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_PAD   = 2'd2;
  localparam logic [1:0] S_MARK  = 2'd3;

  logic [1:0]                          state;
  logic [1:0]                          vs_pipe;
  logic [KW-1:0]                       k;
  logic [BW-1:0]                       frm_cnt;
  logic                                frm_any;
  logic [AW-1:0]                       wr_ptr, rd_ptr, end_ptr, rd_ptr_nxt;
  logic [AW:0]                         cnt;
  logic                                pend;
  logic                                full, empty;
  logic                                vs_rise, close, pix_acc, pix_drop;
  logic                                pix_push, flush_push, pad_push, push_req, push_ok;
  logic                                rd_do, mark_now, hit_old, hit_new, fe_hit;
  logic [VEC_W-1:0]                    pix_in;
  logic [NUM_LANES-1:0]                lane_ld, lane_sel, lane_keep;
  logic [NUM_LANES-1:0][VEC_W-1:0]     lane_q;
  logic [NUM_LANES*VEC_W-1:0]          wr_word;
  logic [NUM_LANES*VEC_W-1:0]          mem [DEPTH];

  logic                                rready_q, fe_q, ovf_q, udf_q;
  logic [NUM_LANES*VEC_W-1:0]          rd_data_q;

`ifdef TEST_PATTERN_EN
  logic [VEC_W-1:0] tp_cnt;

  always_ff @(posedge clk) begin
    if (rst)          tp_cnt <= '0;
    else if (close)   tp_cnt <= '0;
    else if (pix_acc) tp_cnt <= tp_cnt + 1'b1;
  end

  assign pix_in = tp_cnt;
`else
  assign pix_in = bus.pix_data;
`endif

  assign full       = (cnt == (AW+1)'(DEPTH));
  assign empty      = (cnt == '0);
  assign vs_rise    = vs_pipe[0] & ~vs_pipe[1];
  assign close      = vs_rise && (state == S_IDLE);
  assign pix_acc    = bus.pix_de && ((state == S_IDLE) || (state == S_MARK));
  assign pix_drop   = bus.pix_de && ((state == S_FLUSH) || (state == S_PAD));
  assign pix_push   = pix_acc && (k == KW'(NUM_LANES-1));
  assign flush_push = (state == S_FLUSH) && (k != '0) && !full;
  assign pad_push   = (state == S_PAD) && (frm_cnt != '0) && !full;
  assign push_req   = pix_push | flush_push | pad_push;
  assign push_ok    = push_req && !full;
  assign mark_now   = (state == S_PAD) && (frm_cnt == '0);
  assign wr_word    = pad_push ? '0 : lane_q;

  assign rd_do      = bus.rd_en && !empty;
  assign rd_ptr_nxt = rd_ptr + 1'b1;
  // A read can retire the last pad in the same cycle end_ptr is latched
  assign hit_old    = rd_do && pend && (rd_ptr_nxt == end_ptr);
  assign hit_new    = rd_do && mark_now && (rd_ptr_nxt == wr_ptr);
  assign fe_hit     = hit_old | hit_new;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_ld[i]   = pix_acc && (k == KW'(i));
    assign lane_sel[i]  = pix_acc && (k == KW'(i));
    assign lane_keep[i] = (state != S_FLUSH) || (KW'(i) < k);

    vwb_lane #(.VEC_W(VEC_W)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .ld      (lane_ld[i]),
      .sel_new (lane_sel[i]),
      .keep    (lane_keep[i]),
      .din     (pix_in),
      .q       (lane_q[i])
    );
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      vs_pipe <= '0;
      k       <= '0;
      frm_cnt <= '0;
      frm_any <= 1'b0;
    end else begin
      vs_pipe <= {vs_pipe[0], bus.pix_vsync};

      if (pix_acc)         k <= k + 1'b1;
      else if (flush_push) k <= '0;

      // frame length counts stored words so every frame ends burst-aligned in the FIFO
      if (push_ok) frm_cnt <= frm_cnt + 1'b1;

      if (mark_now)     frm_any <= 1'b0;
      else if (push_ok) frm_any <= 1'b1;

      case (state)
        S_IDLE:  if (close && ((k != '0) || frm_any || pix_acc)) state <= S_FLUSH;
        S_FLUSH: if ((k == '0) || !full) state <= S_PAD;
        S_PAD:   if (frm_cnt == '0) state <= S_MARK;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      end_ptr   <= '0;
      cnt       <= '0;
      pend      <= 1'b0;
      rready_q  <= 1'b0;
      rd_data_q <= '0;
      fe_q      <= 1'b0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;

      if (rd_do) begin
        rd_data_q <= mem[rd_ptr];
        rd_ptr    <= rd_ptr_nxt;
      end

      case ({push_ok, rd_do})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase

      if (mark_now) begin
        end_ptr <= wr_ptr;
        pend    <= !hit_new;
      end else if (hit_old) begin
        pend    <= 1'b0;
      end

      fe_q     <= fe_hit;
      rready_q <= (cnt >= (AW+1)'(BURST_LEN));

      if ((pix_push && full) || pix_drop) ovf_q <= 1'b1;
      if (bus.rd_en && empty)             udf_q <= 1'b1;
    end
  end

  assign bus.channel_rready = rready_q;
  assign bus.rd_data        = rd_data_q;
  assign bus.frame_end_flag = fe_q;
  assign bus.wr_overflow    = ovf_q;
  assign bus.rd_underflow   = udf_q;
  assign bus.fill_count     = cnt;
endmodule

// File: doc/video_wr_buffer.md
# video_wr_buffer

Per-channel video ingest buffer feeding the multi-channel DDR write arbiter. It packs a 16-bit pixel stream into 256-bit words and stores them in an internal FIFO. It raises `channel_rready` whenever a full AXI burst is available. On each frame boundary it pads the tail to a burst boundary and pulses `frame_end_flag` when the last word of the frame has been read out. One instance sits in front of each of the five arbiter channels.

## Interface
- `DEPTH`, 64, FIFO depth in 256-bit words; power of two, multiple of `BURST_LEN`
- `BURST_LEN`, 16, words per arbiter burst; power of two
- `clk`  in  1  system clock; pixel input is already synchronous to it
- `rst`  in  1  reset, synchronous and active-high
- `pix_vsync`  in  1  frame sync; rising edge closes the current frame
- `pix_de`  in  1  pixel valid
- `pix_data`  in  16  RGB565 pixel
- `channel_rready`  out  1  at least `BURST_LEN` words buffered
- `rd_en`  in  1  word read strobe from the arbiter
- `rd_data`  out  256  read word
- `frame_end_flag`  out  1  one-cycle pulse marking the last word of a frame
- `wr_overflow`  out  1  sticky: a word or pixel was dropped
- `rd_underflow`  out  1  sticky: `rd_en` was asserted while empty
- `fill_count`  out  log2(DEPTH)+1  words currently stored

## Operation
- **Packer:**
  - Each `pix_de` cycle places `pix_data` in lane k (bits 16k+15:16k) of the staging word.
  - The first pixel goes in lane 0. k counts 0..15.
  - On k=15 the staging word is pushed to the FIFO and k returns to 0.
- **FIFO:**
  - Dual-pointer RAM; pointers are log2(DEPTH) bits and wrap naturally.
  - `fill_count` = writes − reads.
  - A push with `fill_count`==DEPTH drops the word and sets `wr_overflow`.
- **Frame close:** triggered by a `pix_vsync` rising edge, detected on the registered vsync. The state machine proceeds:
  - IDLE → FLUSH if k>0: push the staging word with unused lanes zero, then clear k.
  - FLUSH → PAD: push all-zero words until the frame's word count mod `BURST_LEN` = 0.
  - PAD → MARK: latch `end_ptr` = write pointer after the final pad, set `pend`.
  - MARK → IDLE.
  - A frame with zero words since the last close goes IDLE → IDLE: no pad, no `pend`.
  - FLUSH/PAD stall, one push per cycle, while the FIFO is full; padding is never dropped.
  - Pixels arriving during FLUSH/PAD are dropped and set `wr_overflow`.
- **Read side:**
  - `rd_en` with `fill_count`>0 reads the word at the read pointer into `rd_data` and advances the pointer.
  - `rd_en` when empty: pointer and `rd_data` hold, `rd_underflow` sets.
- **Frame end:**
  - When a read advances the read pointer to equal `end_ptr` while `pend`=1, `frame_end_flag` pulses and `pend` clears.
  - A new close while `pend`=1 overwrites `end_ptr`; only the latest frame end is signalled.
- **Sticky flags:** `wr_overflow` and `rd_underflow` clear only on `rst`.

## Timing
- Reset values:
  - `channel_rready`=0, `rd_data`=0, `frame_end_flag`=0, `wr_overflow`=0, `rd_underflow`=0, `fill_count`=0.
  - Pointers = 0, k=0, `pend`=0, state IDLE.
- Pixel → FIFO: the word is written in the cycle after the 16th `pix_de`, and `fill_count` increments at that edge.
- Vsync → FLUSH: FLUSH is entered 2 cycles after the vsync rising edge (1 cycle sync register, 1 cycle edge detect).
- `channel_rready` is a registered compare (`fill_count` ≥ `BURST_LEN`), lagging `fill_count` by 1 cycle.
- Read latency is 1 cycle: `rd_en` at edge N gives `rd_data` valid after edge N+1. The arbiter asserts `rd_en` for `BURST_LEN` consecutive cycles per burst.
- `frame_end_flag` is coincident with `rd_data` holding the last word of the frame.
- A simultaneous push and pop leaves `fill_count` unchanged. A push while full is dropped even if a pop occurs in the same cycle.
- `rst` mid-burst or mid-pad discards all contents immediately. A frame in flight is lost, with no `frame_end_flag`.

## Configuration
- **`TEST_PATTERN_EN` defined:** `pix_data` is ignored. Each accepted pixel is replaced by a 16-bit counter that increments per `pix_de` and clears on each frame close. This gives deterministic DDR content for bring-up.
- **`TEST_PATTERN_EN` undefined:** `pix_data` is stored unchanged and the counter logic is absent.

## Test plan
- **Basic pack:** after reset, 256 pixels with values 0..255 → 16 words pushed. `channel_rready` rises on the cycle after `fill_count`=16. Word 0 lane 0 = 0x0000, lane 15 = 0x000F.
- **Burst drain:** `rd_en` for 16 cycles → `rd_data` presents words 0..15 in order, each 1 cycle after its strobe. `fill_count` returns to 0, `channel_rready` falls.
- **Partial frame:** 20 pixels, then a vsync rise → 2 real words (second word lanes 4..15 zero) plus 14 zero pad words are pushed. `fill_count`=16. Draining 16 words pulses `frame_end_flag` exactly once, with the 16th word.
- **Overflow:** DEPTH=64 with no reads; 1040 pixels → `fill_count` stops at 64 and the 65th word is dropped. `wr_overflow`=1 and stays 1 until `rst`.
- **Underflow / reset:**
  - `rd_en` while empty → `rd_underflow`=1 and `rd_data` unchanged.
  - `rst` pulsed mid-pad → all outputs return to reset values on the next edge.
- **Test pattern:** with `TEST_PATTERN_EN`, 32 pixels of `pix_data`=0xFFFF → words contain 0x0000..0x001F, and the counter restarts at 0 after a vsync.
